// File: rtl/sram_dp_be.sv
// Simple-dual-port byte-enable SRAM model: registered read with valid, write-first bypass,
// post-reset clear sweep and out-of-range flag. Define SRAM_PARITY_EN for per-byte even parity.
module sram_dp_be #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              wr_ok_s;
  logic              rd_go_s;
  logic              collide_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [DATA_W-1:0] mem_word_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              par_err_s;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register and clear pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_CLEAR) begin
        clr_ptr_r <= clr_ptr_r + 1'b1;
      end else begin
        clr_ptr_r <= clr_ptr_r;
      end
    end
  end

  // Next-state logic: sweep ends after clearing the last implemented word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_ptr_r == LAST_C) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_CLEAR;
    endcase
  end

  // Output logic: busy is a pure function of the state register
  always_comb begin
    init_busy = 1'b1;
    case (state_r)
      ST_CLEAR: init_busy = 1'b1;
      ST_READY: init_busy = 1'b0;
      default:  init_busy = 1'b1;
    endcase
  end

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_ok_s       = wr_en & ~init_busy & ~reset & wr_in_range_s;
  assign rd_go_s       = rd_en & ~init_busy;
  assign collide_s     = wr_ok_s & rd_go_s & rd_in_range_s & (wr_addr == rd_addr);
  // Out-of-range reads never index the array; their data is replaced by zero anyway
  assign rd_idx_s      = rd_in_range_s ? rd_addr : '0;
  assign mem_word_s    = mem[rd_idx_s];

  // Data array: clear sweep has priority, otherwise byte-masked write
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_ptr_r] <= '0;
    end else if (wr_ok_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first merge of the write bytes into the read word
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (collide_s && wr_be[i]) begin
        rd_word_s[8*i +: 8] = wr_data[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = mem_word_s[8*i +: 8];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];

  function automatic logic even_par(input logic [7:0] byte_v);
    return ^byte_v;
  endfunction

  // Parity array tracks the data array byte for byte
  always_ff @(posedge clk) begin
    if (init_busy) begin
      par_mem[clr_ptr_r] <= '0;
    end else if (wr_ok_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          par_mem[wr_addr][i] <= even_par(wr_data[8*i +: 8]);
        end
      end
    end
  end

  // Parity check on stored bytes; a bypassed read carries fresh data and is trusted
  always_comb begin
    par_err_s = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (par_mem[rd_idx_s][i] != even_par(mem_word_s[8*i +: 8])) begin
        par_err_s = 1'b1;
      end else begin
        par_err_s = par_err_s;
      end
    end
    if (collide_s) begin
      par_err_s = 1'b0;
    end else begin
      par_err_s = par_err_s;
    end
  end
`else
  assign par_err_s = 1'b0;
`endif

  // Registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_go_s) begin
      rd_valid <= 1'b1;
      if (rd_in_range_s) begin
        rd_data <= rd_word_s;
        rd_err  <= par_err_s;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_data  <= rd_data;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be (DEPTH=200 so the out-of-range path is reachable).
// Exercises the parity path as well when SRAM_PARITY_EN is defined.
module tb_sram_dp_be;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init_busy;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [BE_W-1:0]   wr_be = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  sram_dp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_errs = 0;
  logic [15:0]     mem_m [256];
  logic [1:0]      pflip_m [256];
  logic [16:0]     sb_q [$];
  logic            ready_m = 1'b0;
  logic [15:0]     last_data = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 256; a++) begin
      mem_m[a]   = 16'h0000;
      pflip_m[a] = 2'b00;
    end
  endtask

  // One clock of stimulus; expected read result pushed now, popped when rd_valid appears
  task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic re, input logic [7:0] ra);
    logic [15:0] w;
    logic        e;
    logic        exp_v;
    logic [16:0] item;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    exp_v = re && ready_m;
    if (exp_v) begin
      if (32'(ra) >= DEPTH) begin
        w = 16'h0000;
        e = 1'b1;
      end else begin
        w = mem_m[ra];
        e = |pflip_m[ra];
        if (we && wa == ra) begin
          e = 1'b0;
          for (int b = 0; b < 2; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
      end
      sb_q.push_back({e, w});
    end
    if (we && ready_m && 32'(wa) < DEPTH) begin
      for (int b = 0; b < 2; b++) begin
        if (be[b]) begin
          mem_m[wa][8*b +: 8] = wd[8*b +: 8];
          pflip_m[wa][b] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        item = sb_q.pop_front();
        last_data = item[15:0];
        check("rd_data", 32'(rd_data), 32'(item[15:0]));
        check("rd_err", 32'(rd_err), 32'(item[16]));
      end
    end
  endtask

  // Reset for two cycles, then count the clear sweep while poking requests that must be ignored
  task automatic reset_and_clear();
    int cnt;
    int vcnt;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    ready_m = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(rd_err), 32'd0);
    reset = 1'b0;
    clear_model();
    last_data = 16'h0000;
    cnt = 0;
    vcnt = 0;
    while (init_busy === 1'b1 && cnt < 1000) begin
      if (cnt >= 100) begin
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 8'd4;
      end
      @(posedge clk); #1;
      cnt++;
      if (rd_valid) vcnt++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("busy_cycles", 32'(cnt), 32'(DEPTH));
    check("busy_no_valid", 32'(vcnt), 32'd0);
    ready_m = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    reset_and_clear();
    // requests during the sweep must have left memory clear
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
    // plain write then read
    step(1'b1, 8'd5, 16'hABCD, 2'b11, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
    // idle cycle: no valid, data holds
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
    check("rd_hold", 32'(rd_data), 32'(last_data));
    // partial byte write
    step(1'b1, 8'd10, 16'h1234, 2'b11, 1'b0, 8'd0);
    step(1'b1, 8'd10, 16'hFF00, 2'b10, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd10);
    // be=0 is a no-op
    step(1'b1, 8'd5, 16'h0000, 2'b00, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
    // collisions: full and partial write-first
    step(1'b1, 8'd7, 16'h5A5A, 2'b11, 1'b1, 8'd7);
    step(1'b1, 8'd5, 16'h1111, 2'b01, 1'b1, 8'd5);
    // back-to-back reads
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd1);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd2);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
    // range boundary
    step(1'b1, 8'hC7, 16'h7E81, 2'b11, 1'b0, 8'd0);
    step(1'b1, 8'hC8, 16'hFFFF, 2'b11, 1'b1, 8'hC7);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'hC8);
    step(1'b1, 8'hC8, 16'h1234, 2'b11, 1'b1, 8'hC8);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'hFF);
    // random traffic around the top of the array
    for (int n = 0; n < 60; n++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(190, 209)), 16'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(190, 209)));
    end
`ifdef SRAM_PARITY_EN
    step(1'b1, 8'd3, 16'h0001, 2'b11, 1'b0, 8'd0);
    dut.par_mem[3][0] = ~dut.par_mem[3][0];
    pflip_m[3][0] = 1'b1;
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
    step(1'b1, 8'd3, 16'h0101, 2'b10, 1'b1, 8'd3);
    step(1'b1, 8'd3, 16'h0002, 2'b01, 1'b0, 8'd0);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
`endif
    // reset in the middle of the sweep restarts it from zero
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_busy", 32'(init_busy), 32'd1);
    reset_and_clear();
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd10);
    step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd7);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
